// File: rtl/brc_hazard_ctrl.sv
// brc_hazard_ctrl: ID-stage branch operand hazard control.
// Tracks in-flight writers in EX/MEM/WB and picks register file, MEM/WB forward, or an ID stall.
module brc_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_id_valid,
  input  logic             i_id_is_branch,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_wen,
  input  logic [REG_W-1:0] i_id_wreg,
  input  logic             i_id_is_load,
  input  logic             i_hold,
  input  logic             i_flush,
  output logic             o_forward_rs,
  output logic             o_forward_rt,
  output logic             o_fwd_rs_wb,
  output logic             o_fwd_rt_wb,
  output logic             o_id_stall,
  output logic [CNT_W-1:0] o_stall_cnt
);

  logic             r_ex_valid, r_ex_wen, r_ex_load;
  logic [REG_W-1:0] r_ex_wreg;
  logic             r_mem_valid, r_mem_wen, r_mem_load;
  logic [REG_W-1:0] r_mem_wreg;
  logic             r_wb_valid, r_wb_wen;
  logic [REG_W-1:0] r_wb_wreg;
  logic [CNT_W-1:0] r_stall_cnt;

  function automatic logic slot_writes(input logic v, input logic wen,
                                       input logic [REG_W-1:0] wreg,
                                       input logic [REG_W-1:0] r);
    return v & wen & (wreg == r) & (r != {REG_W{1'b0}});
  endfunction

  logic w_chk_rs, w_ex_rs, w_mem_rs, w_wb_rs;
  logic w_chk_rt, w_ex_rt, w_mem_rt, w_wb_rt;
  logic w_stall_rs, w_stall_rt, w_stall, w_ex_bubble;

  assign w_chk_rs = i_id_valid & i_id_is_branch & i_id_use_rs;
  assign w_chk_rt = i_id_valid & i_id_is_branch & i_id_use_rt;

  assign w_ex_rs  = slot_writes(r_ex_valid,  r_ex_wen,  r_ex_wreg,  i_id_rs);
  assign w_mem_rs = slot_writes(r_mem_valid, r_mem_wen, r_mem_wreg, i_id_rs);
  assign w_wb_rs  = slot_writes(r_wb_valid,  r_wb_wen,  r_wb_wreg,  i_id_rs);
  assign w_ex_rt  = slot_writes(r_ex_valid,  r_ex_wen,  r_ex_wreg,  i_id_rt);
  assign w_mem_rt = slot_writes(r_mem_valid, r_mem_wen, r_mem_wreg, i_id_rt);
  assign w_wb_rt  = slot_writes(r_wb_valid,  r_wb_wen,  r_wb_wreg,  i_id_rt);

  // Youngest producer wins: EX stalls, a MEM load stalls, else MEM then WB forward.
  assign w_stall_rs = w_chk_rs & (w_ex_rs | (w_mem_rs & r_mem_load));
  assign w_stall_rt = w_chk_rt & (w_ex_rt | (w_mem_rt & r_mem_load));
  assign w_stall    = w_stall_rs | w_stall_rt;

  assign o_id_stall   = w_stall;
  assign o_forward_rs = w_chk_rs & ~w_ex_rs & (w_mem_rs | w_wb_rs) & ~w_stall;
  assign o_forward_rt = w_chk_rt & ~w_ex_rt & (w_mem_rt | w_wb_rt) & ~w_stall;
  assign o_fwd_rs_wb  = w_chk_rs & ~w_ex_rs & ~w_mem_rs & w_wb_rs & ~w_stall;
  assign o_fwd_rt_wb  = w_chk_rt & ~w_ex_rt & ~w_mem_rt & w_wb_rt & ~w_stall;
  assign o_stall_cnt  = r_stall_cnt;

  assign w_ex_bubble = i_flush | w_stall | ~i_id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid  <= 1'b0;
      r_ex_wen    <= 1'b0;
      r_ex_load   <= 1'b0;
      r_ex_wreg   <= {REG_W{1'b0}};
      r_mem_valid <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_load  <= 1'b0;
      r_mem_wreg  <= {REG_W{1'b0}};
      r_wb_valid  <= 1'b0;
      r_wb_wen    <= 1'b0;
      r_wb_wreg   <= {REG_W{1'b0}};
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (!i_hold) begin
      r_wb_valid  <= r_mem_valid;
      r_wb_wen    <= r_mem_wen;
      r_wb_wreg   <= r_mem_wreg;
      r_mem_valid <= r_ex_valid;
      r_mem_wen   <= r_ex_wen;
      r_mem_load  <= r_ex_load;
      r_mem_wreg  <= r_ex_wreg;
      if (w_ex_bubble) begin
        r_ex_valid <= 1'b0;
        r_ex_wen   <= 1'b0;
        r_ex_load  <= 1'b0;
        r_ex_wreg  <= {REG_W{1'b0}};
      end else begin
        r_ex_valid <= 1'b1;
        r_ex_wen   <= i_id_wen;
        r_ex_load  <= i_id_is_load;
        r_ex_wreg  <= i_id_wreg;
      end
      if (w_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

endmodule
